// File: rtl/display_bars_pkg.sv
// Shared types, colours and helpers for the level-bar overlay.
// Imported by the overlay top and its per-band peak-hold channels.
package display_bars_pkg;

    typedef enum logic {
        HOLD  = 1'b0,
        DECAY = 1'b1
    } peak_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK  = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
    localparam rgb_t WHITE  = '{r: 8'd255, g: 8'd255, b: 8'd255};
    localparam rgb_t YELLOW = '{r: 8'd255, g: 8'd255, b: 8'd0};
    localparam rgb_t GREEN  = '{r: 8'd0,   g: 8'd255, b: 8'd0};
    localparam rgb_t RED    = '{r: 8'd255, g: 8'd0,   b: 8'd0};

    // Unsigned min(x, max_h); callers narrow the result to the bar height width.
    function automatic logic [31:0] clamp(input logic [63:0] x, input logic [31:0] max_h);
        return (x > {32'd0, max_h}) ? max_h : x[31:0];
    endfunction

endpackage

// File: rtl/display_bars_peak_hold_channel.sv
// One band: frame-latched height/threshold, threshold-hit flag and a
// peak-hold marker that holds for a number of frames and then decays.
module peak_hold_channel
    import display_bars_pkg::*;
#(
    parameter int VAL_W            = 32,
    parameter int MAX_H            = 359,
    parameter int HW               = 9,
    parameter int PEAK_HOLD_FRAMES = 30,
    parameter int PEAK_DECAY       = 4
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             strobe_en,
    input  logic [VAL_W-1:0] level,
    input  logic [VAL_W-1:0] threshold,
    output logic [HW-1:0]    height,
    output logic [HW-1:0]    thr,
    output logic [HW-1:0]    peak,
    output logic             hit
);

    localparam int CW = $clog2(PEAK_HOLD_FRAMES + 1);

    peak_state_t   state, state_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic [HW-1:0] peak_nxt, dec;
    logic [HW-1:0] h_new, t_new;

    assign h_new = HW'(clamp(64'(level), 32'(MAX_H)));
    assign t_new = HW'(clamp(64'(threshold), 32'(MAX_H)));

    always_ff @(posedge pixel_clk) begin
        if (rst)
            state <= HOLD;
        else if (strobe_en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (h_new >= peak)
            state_nxt = HOLD;
        else if (state == HOLD && hold_cnt == '0)
            state_nxt = DECAY;
    end

    always_comb begin
        peak_nxt = peak;
        hold_nxt = hold_cnt;
        dec      = '0;
        if (h_new >= peak) begin
            peak_nxt = h_new;
            hold_nxt = CW'(PEAK_HOLD_FRAMES);
        end else if (state == HOLD) begin
            if (hold_cnt != '0)
                hold_nxt = hold_cnt - CW'(1);
        end else begin
            // Saturate at zero, but never fall below the live height.
            dec      = (peak > HW'(PEAK_DECAY)) ? peak - HW'(PEAK_DECAY) : '0;
            peak_nxt = (dec > h_new) ? dec : h_new;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            height   <= '0;
            thr      <= '0;
            peak     <= '0;
            hold_cnt <= '0;
            hit      <= 1'b0;
        end else if (strobe_en) begin
            height   <= h_new;
            thr      <= t_new;
            peak     <= peak_nxt;
            hold_cnt <= hold_nxt;
            hit      <= (h_new >= t_new);
        end
    end

endmodule

// File: rtl/display_bars_peak.sv
// N-band level-bar overlay with threshold lines and peak-hold markers.
// Band values latch once per frame; pixel colour is two cycles behind h/v.
module display_bars_peak
    import display_bars_pkg::*;
#(
    parameter int NUM_BARS         = 3,
    parameter int VAL_W            = 32,
    parameter int BAR_REGION_TOP   = 360,
    parameter int BAR_BOTTOM       = 719,
    parameter int BAR_START_X      = 240,
    parameter int BAR_WIDTH        = 40,
    parameter int BAR_SPACING      = 40,
    parameter int VBLANK_LINE      = 720,
    parameter int PEAK_HOLD_FRAMES = 30,
    parameter int PEAK_DECAY       = 4
) (
    input  logic                      pixel_clk,
    input  logic                      rst,
    input  logic [NUM_BARS*VAL_W-1:0] levels,
    input  logic [NUM_BARS*VAL_W-1:0] thresholds,
    input  logic                      freeze,
    input  logic [10:0]               h_count,
    input  logic [9:0]                v_count,
    output logic [7:0]                pixel_red,
    output logic [7:0]                pixel_green,
    output logic [7:0]                pixel_blue,
    output logic [NUM_BARS-1:0]       threshold_hit
);

    localparam int MAX_H = BAR_BOTTOM - BAR_REGION_TOP;
    localparam int HW    = $clog2(MAX_H + 1);
    localparam int PITCH = BAR_WIDTH + BAR_SPACING;
    localparam int BI_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    logic                strobe_en;
    logic [HW-1:0]       height [NUM_BARS];
    logic [HW-1:0]       thr    [NUM_BARS];
    logic [HW-1:0]       peak   [NUM_BARS];
    wire  [NUM_BARS-1:0] hit_w;

    assign strobe_en     = (h_count == 11'd0) && (v_count == 10'(VBLANK_LINE)) && !freeze;
    assign threshold_hit = hit_w;

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_band
        peak_hold_channel #(
            .VAL_W            (VAL_W),
            .MAX_H            (MAX_H),
            .HW               (HW),
            .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES),
            .PEAK_DECAY       (PEAK_DECAY)
        ) u_chan (
            .pixel_clk (pixel_clk),
            .rst       (rst),
            .strobe_en (strobe_en),
            .level     (levels[i*VAL_W +: VAL_W]),
            .threshold (thresholds[i*VAL_W +: VAL_W]),
            .height    (height[i]),
            .thr       (thr[i]),
            .peak      (peak[i]),
            .hit       (hit_w[i])
        );
    end

    logic [BI_W-1:0] bar_idx;
    logic            in_bar;

    always_comb begin
        bar_idx = '0;
        in_bar  = 1'b0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (int'(h_count) >= BAR_START_X + i*PITCH &&
                int'(h_count) <  BAR_START_X + i*PITCH + BAR_WIDTH) begin
                in_bar  = 1'b1;
                bar_idx = BI_W'(i);
            end
        end
        if (int'(v_count) < BAR_REGION_TOP || int'(v_count) > BAR_BOTTOM)
            in_bar = 1'b0;
    end

    // Stage 1: band index, in-bar flag, row
    logic [BI_W-1:0] bar_idx_p1;
    logic            in_bar_p1;
    logic [9:0]      v_p1;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            bar_idx_p1 <= '0;
            in_bar_p1  <= 1'b0;
            v_p1       <= '0;
        end else begin
            bar_idx_p1 <= bar_idx;
            in_bar_p1  <= in_bar;
            v_p1       <= v_count;
        end
    end

    logic [HW-1:0] sel_height, sel_thr, sel_peak;
    logic          sel_hit;
    logic [10:0]   v_ext, thr_row, peak_row, body_row, thr_dist;
    rgb_t          rgb_nxt;

    always_comb begin
        sel_height = height[bar_idx_p1];
        sel_thr    = thr[bar_idx_p1];
        sel_peak   = peak[bar_idx_p1];
        sel_hit    = hit_w[bar_idx_p1];
        v_ext      = {1'b0, v_p1};
        thr_row    = 11'(BAR_BOTTOM) - 11'(sel_thr);
        peak_row   = 11'(BAR_BOTTOM) - 11'(sel_peak);
        body_row   = 11'(BAR_BOTTOM) - 11'(sel_height);
        // Distance taken in the non-negative direction so it never wraps.
        thr_dist   = (v_ext >= thr_row) ? v_ext - thr_row : thr_row - v_ext;
        rgb_nxt    = BLACK;
        if (in_bar_p1) begin
            if (thr_dist <= 11'd1)
                rgb_nxt = GREEN;
            else if (sel_peak != '0 && v_ext == peak_row)
                rgb_nxt = RED;
            else if (v_ext > body_row)
                rgb_nxt = sel_hit ? YELLOW : WHITE;
        end
    end

    // Stage 2: output colour
    rgb_t rgb_p2;

    always_ff @(posedge pixel_clk) begin
        if (rst)
            rgb_p2 <= BLACK;
        else
            rgb_p2 <= rgb_nxt;
    end

    assign pixel_red   = rgb_p2.r;
    assign pixel_green = rgb_p2.g;
    assign pixel_blue  = rgb_p2.b;

endmodule

// File: tb/tb_display_bars_peak.sv
// Directed bench for display_bars_peak: per-cycle compare against a
// frame-level behavioural model plus hand-computed pixel/flag literals.
module tb_display_bars_peak;

    localparam int NB = 3;
    localparam int VW = 32;

    logic             pixel_clk = 1'b0;
    logic             rst = 1'b1;
    logic             freeze = 1'b0;
    logic [NB*VW-1:0] levels = '0;
    logic [NB*VW-1:0] thresholds = '0;
    logic [10:0]      h_count = '0;
    logic [9:0]       v_count = '0;
    logic [7:0]       pixel_red, pixel_green, pixel_blue;
    logic [NB-1:0]    threshold_hit;

    int total = 0;
    int bad   = 0;

    always #5 pixel_clk = ~pixel_clk;

    display_bars_peak dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .levels        (levels),
        .thresholds    (thresholds),
        .freeze        (freeze),
        .h_count       (h_count),
        .v_count       (v_count),
        .pixel_red     (pixel_red),
        .pixel_green   (pixel_green),
        .pixel_blue    (pixel_blue),
        .threshold_hit (threshold_hit)
    );

    // Frame-level model: bars are 240+80*i .. +39, region rows 360..719, MAX_H 359.
    int            m_height [NB];
    int            m_thr    [NB];
    int            m_peak   [NB];
    int            m_hold   [NB];
    bit            m_decay  [NB];
    logic [NB-1:0] m_hit = '0;
    logic [23:0]   exp_p1 = '0;
    logic [23:0]   exp_p2 = '0;
    bit            chk_en = 1'b0;

    function automatic int clampv(logic [VW-1:0] x);
        return (x > 359) ? 359 : int'(x);
    endfunction

    function automatic logic [23:0] model_px(int h, int v);
        int x0;
        int line;
        for (int i = 0; i < NB; i++) begin
            x0 = 240 + i*80;
            if (h >= x0 && h < x0 + 40 && v >= 360 && v <= 719) begin
                line = 719 - m_thr[i];
                if (v - line <= 1 && line - v <= 1) return 24'h00FF00;
                if (m_peak[i] > 0 && v == 719 - m_peak[i]) return 24'hFF0000;
                if (v > 719 - m_height[i]) return m_hit[i] ? 24'hFFFF00 : 24'hFFFFFF;
                return 24'h000000;
            end
        end
        return 24'h000000;
    endfunction

    task automatic model_strobe();
        int h;
        int t;
        int p;
        for (int i = 0; i < NB; i++) begin
            h = clampv(levels[i*VW +: VW]);
            t = clampv(thresholds[i*VW +: VW]);
            m_height[i] = h;
            m_thr[i]    = t;
            m_hit[i]    = (h >= t);
            if (h >= m_peak[i]) begin
                m_peak[i]  = h;
                m_hold[i]  = 30;
                m_decay[i] = 1'b0;
            end else if (!m_decay[i]) begin
                if (m_hold[i] == 0) m_decay[i] = 1'b1;
                else m_hold[i] = m_hold[i] - 1;
            end else begin
                p = m_peak[i] - 4;
                if (p < 0) p = 0;
                m_peak[i] = (p > h) ? p : h;
            end
        end
    endtask

    always @(posedge pixel_clk) begin
        logic [23:0] c;
        c = model_px(int'(h_count), int'(v_count));
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_height[i] = 0; m_thr[i] = 0; m_peak[i] = 0; m_hold[i] = 0; m_decay[i] = 1'b0;
            end
            m_hit  = '0;
            exp_p1 = '0;
            exp_p2 = '0;
            chk_en = 1'b1;
        end else begin
            if (h_count == 11'd0 && v_count == 10'd720 && !freeze) model_strobe();
            exp_p2 = exp_p1;
            exp_p1 = c;
        end
    end

    always @(negedge pixel_clk) begin
        if (chk_en) begin
            total++;
            if ({pixel_red, pixel_green, pixel_blue} !== exp_p2) begin
                bad++;
                $display("FAIL pixel_stream t=%0t got=%h want=%h", $time,
                         {pixel_red, pixel_green, pixel_blue}, exp_p2);
            end
            total++;
            if (threshold_hit !== m_hit) begin
                bad++;
                $display("FAIL hit_stream t=%0t got=%b want=%b", $time, threshold_hit, m_hit);
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive_px(int h, int v);
        h_count = 11'(h);
        v_count = 10'(v);
    endtask

    task automatic check_px(string name, int h, int v, logic [23:0] want);
        drive_px(h, v);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        chk(name, 32'({pixel_red, pixel_green, pixel_blue}), 32'(want));
    endtask

    task automatic strobe();
        drive_px(0, 720);
        @(negedge pixel_clk);
        drive_px(250, 600);
        @(negedge pixel_clk);
    endtask

    task automatic set_bands(int l0, int l1, int l2, int t0, int t1, int t2);
        levels     = {32'(l2), 32'(l1), 32'(l0)};
        thresholds = {32'(t2), 32'(t1), 32'(t0)};
    endtask

    task automatic sweep();
        int hs [8] = '{0, 245, 279, 280, 330, 410, 439, 1279};
        int vs [9] = '{359, 360, 500, 619, 620, 640, 700, 718, 719};
        foreach (hs[a]) begin
            foreach (vs[b]) begin
                drive_px(hs[a], vs[b]);
                @(negedge pixel_clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_px(250, 620);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        chk("reset_rgb", 32'({pixel_red, pixel_green, pixel_blue}), 32'h0);
        chk("reset_hit", 32'(threshold_hit), 32'h0);
        rst = 1'b0;

        set_bands(100, 200, 400, 50, 250, 0);
        check_px("pre_strobe_blank", 250, 620, 24'h000000);
        strobe();
        chk("hit_after_strobe", 32'(threshold_hit), 32'h5);
        chk("model_h0", 32'(m_height[0]), 32'd100);
        chk("model_h1", 32'(m_height[1]), 32'd200);
        chk("model_h2", 32'(m_height[2]), 32'd359);
        check_px("b0_peak_619", 250, 619, 24'hFF0000);
        check_px("b0_body_620", 250, 620, 24'hFFFF00);
        check_px("b0_above_618", 250, 618, 24'h000000);
        check_px("b0_line_668", 250, 668, 24'h00FF00);
        check_px("b0_line_670", 250, 670, 24'h00FF00);
        check_px("b0_body_671", 250, 671, 24'hFFFF00);
        check_px("b1_body_white", 330, 620, 24'hFFFFFF);
        check_px("b2_peak_top", 420, 360, 24'hFF0000);
        check_px("b2_body_361", 420, 361, 24'hFFFF00);
        check_px("b2_line_718", 420, 718, 24'h00FF00);
        check_px("gap_280", 280, 620, 24'h000000);
        sweep();

        // Level change mid-frame is invisible until the next strobe.
        drive_px(250, 500);
        @(negedge pixel_clk);
        set_bands(50, 200, 400, 50, 250, 0);
        check_px("midframe_hold", 250, 620, 24'hFFFF00);
        sweep();
        strobe();
        check_px("after_strobe_620", 250, 620, 24'h000000);
        check_px("peak_kept_619", 250, 619, 24'hFF0000);

        // Peak hold/decay with a two-strobe freeze inside the hold window.
        set_bands(300, 200, 400, 359, 250, 0);
        strobe();
        check_px("peak_load_419", 250, 419, 24'hFF0000);
        set_bands(0, 200, 400, 359, 250, 0);
        repeat (29) strobe();
        freeze = 1'b1;
        set_bands(350, 0, 0, 0, 0, 0);
        repeat (2) strobe();
        chk("freeze_hit", 32'(threshold_hit), 32'h4);
        check_px("freeze_no_peak_369", 250, 369, 24'h000000);
        freeze = 1'b0;
        set_bands(0, 200, 400, 359, 250, 0);
        repeat (2) strobe();
        check_px("hold_end_419", 250, 419, 24'hFF0000);
        strobe();
        check_px("decay1_423", 250, 423, 24'hFF0000);
        check_px("decay1_419_gone", 250, 419, 24'h000000);
        repeat (73) strobe();
        check_px("decay_near_715", 250, 715, 24'hFF0000);
        strobe();
        check_px("decay_done_715", 250, 715, 24'h000000);
        check_px("peak_zero_719", 250, 719, 24'h000000);
        sweep();

        // Reset during the active region.
        set_bands(100, 200, 400, 50, 250, 0);
        strobe();
        check_px("pre_reset_body", 250, 620, 24'hFFFF00);
        rst = 1'b1;
        @(negedge pixel_clk);
        chk("reset_mid_rgb", 32'({pixel_red, pixel_green, pixel_blue}), 32'h0);
        rst = 1'b0;
        check_px("post_reset_b0", 250, 620, 24'h000000);
        check_px("post_reset_b1", 330, 620, 24'h000000);
        chk("post_reset_hit", 32'(threshold_hit), 32'h0);
        strobe();
        check_px("edge_h0", 0, 620, 24'h000000);
        check_px("edge_h1279", 1279, 620, 24'h000000);
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
